// File: rtl/window_mac_pkg.sv
// Shared widths and lane helper for the window_mac slice.
// Included by the top, the adder tree and the bus interface.
package window_mac_pkg;
   localparam int LANES  = 16;
   localparam int PIX_W  = 8;
   localparam int WGT_W  = 8;
   localparam int PROD_W = 17;
   localparam int SUM_W  = 21;
   localparam int BEAT_W = LANES * PIX_W;
   localparam int CNT_W  = 4;

   function automatic logic [7:0] lane(input logic [BEAT_W-1:0] w, input int k);
      return w[8*k +: 8];
   endfunction
endpackage

// File: rtl/window_mac_if.sv
// Window/filter beat in, accumulated result out; each side is a valid/ready pair.
interface window_mac_if
   import window_mac_pkg::*;
#(
   parameter int ACC_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [BEAT_W-1:0] win;
   logic [BEAT_W-1:0] filt;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;

   modport master (
      output in_valid, win, filt, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, win, filt, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/window_adder_tree.sv
// Combinational 16-term signed adder tree, four levels, SUM_W wide throughout.
module window_adder_tree
   import window_mac_pkg::*;
(
   input  logic [LANES-1:0][PROD_W-1:0] prod,
   output logic signed [SUM_W-1:0]      sum
);
   logic signed [SUM_W-1:0] l0 [LANES];
   logic signed [SUM_W-1:0] l1 [LANES/2];
   logic signed [SUM_W-1:0] l2 [LANES/4];
   logic signed [SUM_W-1:0] l3 [LANES/8];

   always_comb begin
      for (int i = 0; i < LANES; i++)
         l0[i] = {{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
      for (int i = 0; i < LANES/2; i++)
         l1[i] = l0[2*i] + l0[2*i+1];
      for (int i = 0; i < LANES/4; i++)
         l2[i] = l1[2*i] + l1[2*i+1];
      for (int i = 0; i < LANES/8; i++)
         l3[i] = l2[2*i] + l2[2*i+1];
      sum = l3[0] + l3[1];
   end
endmodule

// File: rtl/window_mac.sv
// 4x4 window dot product with ACC_LEN-deep accumulation and a stallable pipeline.
// Optional WINDOW_MAC_RELU_EN clamps negative group results to zero on output.
module window_mac
   import window_mac_pkg::*;
#(
   parameter int ACC_LEN = 4,
   parameter int ACC_W   = 32
)(
   input logic         clk,
   input logic         rst,
   window_mac_if.slave bus
);
   localparam int STAGES = 2;

   // [0] captured beat, [1] products, [2] tree sum feeding the accumulator
   logic [STAGES:0]               vld_pipe;
   logic [BEAT_W-1:0]             win_q;
   logic [BEAT_W-1:0]             filt_q;
   logic [LANES-1:0][PROD_W-1:0]  prod;
   logic [LANES-1:0][PROD_W-1:0]  prod_q;
   logic signed [SUM_W-1:0]       sum;
   logic signed [SUM_W-1:0]       sum_q;
   logic signed [ACC_W-1:0]       sum_ext;
   logic signed [ACC_W-1:0]       acc;
   logic signed [ACC_W-1:0]       acc_nxt;
   logic signed [ACC_W-1:0]       res;
   logic [CNT_W-1:0]              grp_cnt;
   logic                          out_valid_q;
   logic [ACC_W-1:0]              out_data_q;
   logic                          stall;
   logic                          accept;
   logic                          last;
   logic                          done;

   assign stall         = out_valid_q && !bus.out_ready;
   assign bus.in_ready  = !rst && !stall;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [WGT_W-1:0]         wgt;
      logic signed [PROD_W-1:0] px;
      logic signed [PROD_W-1:0] wt;

      assign wgt     = lane(filt_q, k);
      assign px      = {{(PROD_W-PIX_W){1'b0}}, lane(win_q, k)};
      assign wt      = {{(PROD_W-WGT_W){wgt[WGT_W-1]}}, wgt};
      assign prod[k] = px * wt;
   end

   window_adder_tree u_tree (
      .prod (prod_q),
      .sum  (sum)
   );

   assign sum_ext = {{(ACC_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
   assign last    = (grp_cnt == CNT_W'(ACC_LEN-1));
   assign done    = vld_pipe[2] && last;
   assign acc_nxt = (grp_cnt == '0) ? sum_ext : acc + sum_ext;

`ifdef WINDOW_MAC_RELU_EN
   assign res = acc_nxt[ACC_W-1] ? '0 : acc_nxt;
`else
   assign res = acc_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe    <= '0;
         win_q       <= '0;
         filt_q      <= '0;
         prod_q      <= '0;
         sum_q       <= '0;
         acc         <= '0;
         grp_cnt     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (!stall) begin
         vld_pipe <= {vld_pipe[STAGES-1:0], accept};
         if (accept) begin
            win_q  <= bus.win;
            filt_q <= bus.filt;
         end
         prod_q <= prod;
         sum_q  <= sum;
         if (vld_pipe[2]) begin
            acc     <= acc_nxt;
            grp_cnt <= last ? '0 : grp_cnt + 1'b1;
         end
         // Not stalled means any pending result is being taken this edge.
         out_valid_q <= done;
         if (done)
            out_data_q <= res;
      end
   end
endmodule

// File: tb/tb_window_mac.sv
// Directed bench for window_mac: one ACC_LEN=1 and one ACC_LEN=4 instance.
module tb_window_mac;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

`ifdef WINDOW_MAC_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   always #5 clk = ~clk;

   window_mac_if #(.ACC_W(32)) b1 ();
   window_mac_if #(.ACC_W(32)) b4 ();

   window_mac #(.ACC_LEN(1), .ACC_W(32)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   window_mac #(.ACC_LEN(4), .ACC_W(32)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   function automatic int relu(input int v);
      return (RELU && v < 0) ? 0 : v;
   endfunction

   function automatic logic [127:0] one_lane(input int k, input logic [7:0] v);
      logic [127:0] r;
      r = '0;
      r[8*k +: 8] = v;
      return r;
   endfunction

   task automatic send1(input logic [127:0] w, input logic [127:0] f);
      b1.win = w; b1.filt = f; b1.in_valid = 1'b1;
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
   endtask

   task automatic send4(input logic [127:0] w, input logic [127:0] f);
      b4.win = w; b4.filt = f; b4.in_valid = 1'b1;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.win = '0; b1.filt = '0;
      b4.in_valid = 1'b0; b4.out_ready = 1'b1; b4.win = '0; b4.filt = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready1 got %b want 0", b1.in_ready); end
      checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready4 got %b want 0", b4.in_ready); end
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid1 got %b want 0", b1.out_valid); end
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid4 got %b want 0", b4.out_valid); end
      checks++; if (b4.out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data4 got %0d want 0", $signed(b4.out_data)); end
      rst = 1'b0;
      #1;
      checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", b1.in_ready); end
   endtask

   task automatic test_unit_latency;
      send1({16{8'd1}}, {16{8'd1}});
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         checks++;
         if (b1.out_valid !== (c == 3)) begin
            errors++; $display("FAIL unit_valid c=%0d got %b want %b", c, b1.out_valid, (c == 3));
         end
         if (c == 3) begin
            checks++;
            if (b1.out_data !== 32'd16) begin errors++; $display("FAIL unit_data got %0d want 16", $signed(b1.out_data)); end
         end
      end
   endtask

   task automatic test_negative;
      int exp;
      exp = relu(-522240);
      send1({16{8'd255}}, {16{8'h80}});
      repeat (3) @(posedge clk);
      #1;
      checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL neg_valid got %b want 1", b1.out_valid); end
      checks++; if (b1.out_data !== 32'(exp)) begin errors++; $display("FAIL neg_data got %0d want %0d", $signed(b1.out_data), exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_lane13;
      int exp;
      exp = relu(-21);
      send1(one_lane(13, 8'd7), one_lane(13, 8'hFD));
      repeat (3) @(posedge clk);
      #1;
      checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL lane13_valid got %b want 1", b1.out_valid); end
      checks++; if (b1.out_data !== 32'(exp)) begin errors++; $display("FAIL lane13_data got %0d want %0d", $signed(b1.out_data), exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 3; i++) send1(one_lane(0, 8'(i)), one_lane(0, 8'd1));
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (b1.out_valid !== (i <= 3)) begin
            errors++; $display("FAIL b2b_valid i=%0d got %b want %b", i, b1.out_valid, (i <= 3));
         end
         if (i <= 3) begin
            checks++;
            if (b1.out_data !== 32'(i)) begin errors++; $display("FAIL b2b_data i=%0d got %0d want %0d", i, $signed(b1.out_data), i); end
         end
      end
   endtask

   task automatic test_group;
      send4({16{8'd1}}, {16{8'd1}});
      send4({{6{8'd0}}, {10{8'd1}}}, {16{8'd1}});
      send4(one_lane(0, 8'd3), one_lane(0, 8'hFF));
      send4(one_lane(0, 8'd1), one_lane(0, 8'd1));
      for (int c = 3; c <= 7; c++) begin
         if (c > 3) begin @(posedge clk); #1; end
         checks++;
         if (b4.out_valid !== (c == 6)) begin
            errors++; $display("FAIL grp_valid c=%0d got %b want %b", c, b4.out_valid, (c == 6));
         end
         if (c == 6) begin
            checks++;
            if (b4.out_data !== 32'd24) begin errors++; $display("FAIL grp_data got %0d want 24", $signed(b4.out_data)); end
         end
      end
      repeat (4) send4(one_lane(0, 8'd1), one_lane(0, 8'd1));
      repeat (2) @(posedge clk);
      #1;
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL grp2_early got %b want 0", b4.out_valid); end
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL grp2_valid got %b want 1", b4.out_valid); end
      checks++; if (b4.out_data !== 32'd4) begin errors++; $display("FAIL grp2_data got %0d want 4", $signed(b4.out_data)); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      b4.out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         b4.win = one_lane(0, (i < 4) ? 8'd1 : 8'd2);
         b4.filt = one_lane(0, 8'd1);
         b4.in_valid = 1'b1;
         checks++;
         if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL stall_pre_ready i=%0d got %b want 1", i, b4.in_ready); end
         @(posedge clk); #1;
      end
      b4.win = one_lane(0, 8'd2);
      for (int c = 0; c < 5; c++) begin
         checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got %b want 0", c, b4.in_ready); end
         checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got %b want 1", c, b4.out_valid); end
         checks++; if (b4.out_data !== 32'd4) begin errors++; $display("FAIL stall_data c=%0d got %0d want 4", c, $signed(b4.out_data)); end
         @(posedge clk); #1;
      end
      b4.out_ready = 1'b1;
      #1;
      checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", b4.in_ready); end
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         checks++;
         if (b4.out_valid !== (c == 3)) begin
            errors++; $display("FAIL release_valid c=%0d got %b want %b", c, b4.out_valid, (c == 3));
         end
         if (c == 3) begin
            checks++;
            if (b4.out_data !== 32'd8) begin errors++; $display("FAIL release_data got %0d want 8", $signed(b4.out_data)); end
         end
      end
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL release_clear got %b want 0", b4.out_valid); end
   endtask

   task automatic test_reset_mid_group;
      send4(one_lane(0, 8'd100), one_lane(0, 8'd1));
      send4(one_lane(0, 8'd100), one_lane(0, 8'd1));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", b4.out_valid); end
      checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", b4.in_ready); end
      repeat (4) send4(one_lane(0, 8'd5), one_lane(0, 8'd1));
      repeat (2) @(posedge clk);
      #1;
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_early got %b want 0", b4.out_valid); end
      @(posedge clk); #1;
      checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_res_valid got %b want 1", b4.out_valid); end
      checks++; if (b4.out_data !== 32'd20) begin errors++; $display("FAIL mid_rst_data got %0d want 20", $signed(b4.out_data)); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_unit_latency();
      test_negative();
      test_lane13();
      test_back_to_back();
      test_group();
      test_stall();
      test_reset_mid_group();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
